// File: rtl/spi_attn_scheduler_if.sv
// Requester and serializer signal bundle for the attenuator SPI scheduler.
// The slave side belongs to the scheduler, and the master side belongs to the requesters and serializer.
interface spi_attn_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int ATTN_W = 6,
  parameter int ADDR_W = 4,
  parameter int REG_W  = 32
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*ATTN_W-1:0] atten_data;
  logic [NUM_CH-1:0]        ack;
  logic                     busy;
  logic [REG_W-1:0]         ser_data;
  logic                     ser_ld;
  logic                     ser_cs;
  logic [ADDR_W-1:0]        last_chan;
  logic                     timeout_err;

  modport master (
    output req, atten_data, ser_cs,
    input  ack, busy, ser_data, ser_ld, last_chan, timeout_err
  );

  modport slave (
    input  req, atten_data, ser_cs,
    output ack, busy, ser_data, ser_ld, last_chan, timeout_err
  );
endinterface

// File: rtl/spi_attn_scheduler.sv
// Round-robin sharing of one SPI serializer among NUM_CH attenuator requesters; all outputs are registered.
// Flow: grant (1 cycle) -> ser_ld for LD_CYCLES -> CS high then low (each wait bounded by TIMEOUT) -> one-cycle ack.
module spi_attn_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int ATTN_W    = 6,
  parameter int ADDR_W    = 4,
  parameter int REG_W     = 32,
  parameter int LD_CYCLES = 4,
  parameter int TIMEOUT   = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_attn_scheduler_if.slave bus
);
  localparam int LDW = $clog2(LD_CYCLES);
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [NUM_CH-1:0] ACK_ONE = NUM_CH'(1);

  typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  grant;
  logic [ADDR_W-1:0]  winner;
  logic               found;
  logic [NUM_CH-1:0]  req_rot;
  logic [ATTN_W-1:0]  code;
  logic [REG_W-1:0]   frame;
  logic [LDW-1:0]     ld_cnt;
  logic [TW-1:0]      wait_cnt;

  // Rotate the requests so that bit 0 is the pointer position. The lowest set bit is then the winner.
  always_comb begin
    req_rot = NUM_CH'({bus.req, bus.req} >> ptr);
    found   = 1'b0;
    winner  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found  = 1'b1;
        winner = ADDR_W'((int'(ptr) + i) % NUM_CH);
      end
    end
    code = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (winner == ADDR_W'(c)) code = bus.atten_data[c*ATTN_W +: ATTN_W];
    end
    frame                  = '0;
    frame[ATTN_W-1:0]      = code;
    frame[ATTN_W +: ADDR_W] = winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      grant           <= '0;
      ld_cnt          <= '0;
      wait_cnt        <= '0;
      bus.ack         <= '0;
      bus.busy        <= 1'b0;
      bus.ser_data    <= '0;
      bus.ser_ld      <= 1'b0;
      bus.last_chan   <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: if (|bus.req) state <= ARB;
        ARB: begin
          if (found) begin
            bus.ser_data  <= frame;
            bus.last_chan <= winner;
            grant         <= winner;
            ptr           <= (winner == ADDR_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
            bus.busy      <= 1'b1;
            bus.ser_ld    <= 1'b1;
            ld_cnt        <= '0;
            state         <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (ld_cnt == LDW'(LD_CYCLES - 1)) begin
            bus.ser_ld <= 1'b0;
            wait_cnt   <= '0;
            state      <= WAIT_HI;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (bus.ser_cs) begin
            wait_cnt <= '0;
            state    <= WAIT_LO;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.ack         <= ACK_ONE << grant;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          // On a timeout the requester is still acked so that it is never left hanging.
          if (!bus.ser_cs) begin
            bus.ack <= ACK_ONE << grant;
            state   <= DONE;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.ack         <= ACK_ONE << grant;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_attn_scheduler.sv
// Directed, table-driven bench for spi_attn_scheduler with a behavioural serializer CS model.
module tb_spi_attn_scheduler;
  localparam int NUM_CH = 4;
  localparam int ATTN_W = 6;
  localparam int ADDR_W = 4;
  localparam int REG_W  = 32;

  typedef struct {
    logic [3:0]  add;
    int          ch;
    logic [31:0] data;
    int          delay;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  int   cs_delay = 6;
  int   cs_len   = 4;
  bit   model_en = 1'b1;

  spi_attn_scheduler_if #(.NUM_CH(NUM_CH), .ATTN_W(ATTN_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus();

  spi_attn_scheduler #(
    .NUM_CH(NUM_CH), .ATTN_W(ATTN_W), .ADDR_W(ADDR_W), .REG_W(REG_W),
    .LD_CYCLES(4), .TIMEOUT(4096)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: CS rises cs_delay cycles after the rising edge of ld and stays high for cs_len cycles.
  initial begin
    bit ld_prev;
    bit armed;
    int cnt;
    ld_prev    = 1'b0;
    armed      = 1'b0;
    cnt        = 0;
    bus.ser_cs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed      = 1'b0;
        bus.ser_cs = 1'b0;
      end else begin
        if (bus.ser_ld && !ld_prev && model_en) begin
          armed = 1'b1;
          cnt   = 0;
        end
        if (armed) begin
          cnt++;
          if (cnt == cs_delay) bus.ser_cs = 1'b1;
          if (cnt >= cs_delay + cs_len) begin
            bus.ser_cs = 1'b0;
            armed      = 1'b0;
          end
        end
      end
      ld_prev = bus.ser_ld;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_code(input int ch, input logic [5:0] code);
    bus.atten_data[ch*ATTN_W +: ATTN_W] = code;
  endtask

  // Wait for an ack and check it. Then release that channel's request and confirm that busy drops.
  task automatic run_txn(input logic [3:0] add, input int exp_ch, input logic [31:0] exp_data,
                         input int delay, input string tag);
    bit         got;
    int         ld_cycles;
    logic [3:0] ackv;
    logic [3:0] exp_ack;
    got       = 1'b0;
    ld_cycles = 0;
    ackv      = '0;
    exp_ack   = 4'b0001 << exp_ch;
    cs_delay  = delay;
    bus.req   = bus.req | add;
    for (int c = 0; c < delay + 200 && !got; c++) begin
      @(posedge clk);
      #1;
      if (bus.ser_ld) ld_cycles++;
      if (|bus.ack) begin
        got  = 1'b1;
        ackv = bus.ack;
      end
    end
    check({tag, " ack_seen"}, 32'(got), 32'd1);
    check({tag, " ack"}, 32'(ackv), 32'(exp_ack));
    check({tag, " ser_data"}, bus.ser_data, exp_data);
    check({tag, " last_chan"}, 32'(bus.last_chan), 32'(exp_ch));
    check({tag, " ld_cycles"}, 32'(ld_cycles), 32'd4);
    check({tag, " busy_at_ack"}, 32'(bus.busy), 32'd1);
    bus.req[exp_ch] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " ack_cleared"}, 32'(bus.ack), 32'd0);
  endtask

  task automatic wait_ld(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.ser_ld) seen = 1'b1;
    end
    check({tag, " ld_seen"}, 32'(seen), 32'd1);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{4'b1111, 0, 32'h11, 6};
    vt[1] = '{4'b0000, 1, 32'h45, 3};
    vt[2] = '{4'b0000, 2, 32'hAA, 6};
    vt[3] = '{4'b0001, 3, 32'hFF, 6};
    vt[4] = '{4'b0000, 0, 32'h11, 6};
    vt[5] = '{4'b0100, 2, 32'hAA, 600};
    vt[6] = '{4'b0101, 0, 32'h11, 6};
    vt[7] = '{4'b0000, 2, 32'hAA, 6};
    vt[8] = '{4'b1010, 3, 32'hFF, 6};
    vt[9] = '{4'b0000, 1, 32'h45, 6};

    rst_n          = 1'b0;
    bus.req        = 4'b1111;
    bus.atten_data = '0;
    set_code(0, 6'h11);
    set_code(1, 6'h05);
    set_code(2, 6'h2A);
    set_code(3, 6'h3F);

    repeat (3) @(negedge clk);
    check("rst ack", 32'(bus.ack), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst ser_ld", 32'(bus.ser_ld), 32'd0);
    check("rst ser_data", bus.ser_data, 32'd0);
    check("rst last_chan", 32'(bus.last_chan), 32'd0);
    check("rst timeout_err", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_txn(vt[v].add, vt[v].ch, vt[v].data, vt[v].delay, $sformatf("vec%0d", v));
    end

    // A request that is dropped by the time the grant cycle samples it produces no grant.
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = 4'b0000;
    begin
      bit saw_ack;
      bit saw_busy;
      saw_ack  = 1'b0;
      saw_busy = 1'b0;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (|bus.ack) saw_ack = 1'b1;
        if (bus.busy || bus.ser_ld) saw_busy = 1'b1;
      end
      check("drop_arb ack", 32'(saw_ack), 32'd0);
      check("drop_arb busy", 32'(saw_busy), 32'd0);
    end
    check("pre_timeout err", 32'(bus.timeout_err), 32'd0);

    // The serializer never answers, so the transaction times out, acks, and sets the sticky error flag.
    model_en = 1'b0;
    run_txn(4'b0001, 0, 32'h11, 4500, "timeout");
    check("timeout err", 32'(bus.timeout_err), 32'd1);
    model_en = 1'b1;
    run_txn(4'b0010, 1, 32'h45, 6, "post_timeout");
    check("timeout sticky", 32'(bus.timeout_err), 32'd1);

    // Reset during LOAD. The pointer before reset is 3, so a grant to ch2 for 1100 proves the restart from 0.
    bus.req = 4'b0100;
    wait_ld("midrst");
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b1100;
    #1;
    check("midrst ser_ld", 32'(bus.ser_ld), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst ack", 32'(bus.ack), 32'd0);
    check("midrst last_chan", 32'(bus.last_chan), 32'd0);
    check("midrst timeout_err", 32'(bus.timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'b0000, 2, 32'hAA, 6, "midrst_a");
    run_txn(4'b0000, 3, 32'hFF, 6, "midrst_b");

    // After the grant, the request is dropped and the code is changed. The frame in flight and the ack are not affected.
    bus.req = 4'b0001;
    wait_ld("late");
    bus.req = 4'b0000;
    set_code(0, 6'h00);
    begin
      bit         got;
      logic [3:0] ackv;
      got  = 1'b0;
      ackv = '0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clk);
        #1;
        if (|bus.ack) begin
          got  = 1'b1;
          ackv = bus.ack;
        end
      end
      check("late ack", 32'(ackv), 32'h1);
      check("late ser_data", bus.ser_data, 32'h11);
    end
    set_code(0, 6'h11);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
